// File: rtl/button_cond_pkg.sv
`default_nettype none
// ============================================================================
// Module      : button_cond_pkg
// Description : Shared types, default timing constants and the counter-width
//               helper for the push-button conditioner.
// Revision    : 1.0 - initial release
// ============================================================================
package button_cond_pkg;

    // Default timings assume a 50 MHz system clock.
    localparam int C_DEBOUNCE_CYCLES = 500000;    // 10 ms
    localparam int C_HOLD_CYCLES     = 25000000;  // 500 ms
    localparam int C_REPEAT_PERIOD   = 10000000;  // 200 ms
    localparam int C_GAP_CYCLES      = 50000;     // 1 ms

    typedef enum logic [2:0] {
        IDLE         = 3'd0,
        PRESS_QUAL   = 3'd1,
        HELD         = 3'd2,
        RELEASE_QUAL = 3'd3,
        GAP          = 3'd4,
        REPEAT       = 3'd5
    } state_t;

    // One shared counter covers every phase, so it is sized for the largest
    // of the timing parameters (it only ever counts up to that value minus 1).
    function automatic int cnt_width(input int a, input int b, input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return (m < 2) ? 1 : $clog2(m);
    endfunction

endpackage : button_cond_pkg
`default_nettype wire

// File: rtl/button_conditioner_if.sv
`default_nettype none
// ============================================================================
// Module      : button_conditioner_if
// Description : Raw key inputs and conditioned outputs of the two-channel
//               button conditioner. slave = conditioner side, master = the
//               side that supplies the keys and consumes the results.
// Revision    : 1.0 - initial release
// ============================================================================
interface button_conditioner_if;

    logic [1:0] key_n;        // raw, asynchronous, active-low
    logic [1:0] buttons_n;    // conditioned level, active-low
    logic [1:0] press_pulse;  // one-cycle strobe per accepted press
    logic [1:0] repeating;    // channel is in its auto-repeat phase

    modport slave (
        input  key_n,
        output buttons_n,
        output press_pulse,
        output repeating
    );

    modport master (
        output key_n,
        input  buttons_n,
        input  press_pulse,
        input  repeating
    );

endinterface : button_conditioner_if
`default_nettype wire

// File: rtl/button_channel.sv
`default_nettype none
// ============================================================================
// Module      : button_channel
// Description : One button: 2-flop synchronizer, press/release debouncer and
//               auto-repeat generator sharing a single phase counter.
//               All outputs are registered and decoded from the next state.
// Revision    : 1.0 - initial release
// ============================================================================
module button_channel
    import button_cond_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = C_DEBOUNCE_CYCLES,
    parameter int HOLD_CYCLES     = C_HOLD_CYCLES,
    parameter int REPEAT_PERIOD   = C_REPEAT_PERIOD,
    parameter int GAP_CYCLES      = C_GAP_CYCLES
)(
    input  logic clk_clk,
    input  logic reset_reset_n,
    input  logic key_n,
    output logic buttons_n,
    output logic press_pulse,
    output logic repeating
);

    localparam int CW = cnt_width(DEBOUNCE_CYCLES, HOLD_CYCLES, REPEAT_PERIOD, GAP_CYCLES);

    // Terminal counts for each phase.
    localparam logic [CW-1:0] C_DEB_LAST  = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0] C_HOLD_LAST = CW'(HOLD_CYCLES - 1);
    localparam logic [CW-1:0] C_GAP_LAST  = CW'(GAP_CYCLES - 1);
    localparam logic [CW-1:0] C_REP_LAST  = CW'(REPEAT_PERIOD - GAP_CYCLES - 1);

    logic [1:0]    r_sync;        // [0] first stage, [1] second stage
    state_t        r_state;
    logic [CW-1:0] r_cnt;
    logic          r_buttons_n;
    logic          r_press_pulse;
    logic          r_repeating;
    logic          w_p;           // 1 = button pressed (synchronized)

    assign w_p = ~r_sync[1];

    // Synchronizer, phase FSM and registered outputs decoded from the next state.
    always_ff @(posedge clk_clk) begin
        if (!reset_reset_n) begin
            r_sync        <= 2'b11;
            r_state       <= IDLE;
            r_cnt         <= '0;
            r_buttons_n   <= 1'b1;
            r_press_pulse <= 1'b0;
            r_repeating   <= 1'b0;
        end else begin
            r_sync        <= {r_sync[0], key_n};
            r_press_pulse <= 1'b0;

            case (r_state)
                IDLE: begin
                    if (w_p) begin
                        r_state <= PRESS_QUAL;
                        r_cnt   <= '0;
                    end
                end

                PRESS_QUAL: begin
                    if (!w_p) begin
                        r_state <= IDLE;                  // bounce rejected
                    end else if (r_cnt == C_DEB_LAST) begin
                        r_state       <= HELD;
                        r_cnt         <= '0;
                        r_buttons_n   <= 1'b0;
                        r_press_pulse <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end

                HELD: begin
                    if (!w_p) begin
                        r_state <= RELEASE_QUAL;
                        r_cnt   <= '0;
                    end else if (r_cnt == C_HOLD_LAST) begin
                        r_state     <= GAP;
                        r_cnt       <= '0;
                        r_buttons_n <= 1'b1;
                        r_repeating <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end

                RELEASE_QUAL: begin
                    if (w_p) begin
                        r_state <= HELD;                  // hold timer restarts
                        r_cnt   <= '0;
                    end else if (r_cnt == C_DEB_LAST) begin
                        r_state     <= IDLE;
                        r_buttons_n <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end

                GAP: begin
                    // The key is only looked at once the synthetic release ends.
                    if (r_cnt == C_GAP_LAST) begin
                        r_cnt <= '0;
                        if (w_p) begin
                            r_state       <= REPEAT;
                            r_buttons_n   <= 1'b0;
                            r_press_pulse <= 1'b1;
                        end else begin
                            r_state     <= IDLE;          // output already released
                            r_repeating <= 1'b0;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end

                REPEAT: begin
                    if (!w_p) begin
                        r_state     <= RELEASE_QUAL;
                        r_cnt       <= '0;
                        r_repeating <= 1'b0;
                    end else if (r_cnt == C_REP_LAST) begin
                        r_state     <= GAP;
                        r_cnt       <= '0;
                        r_buttons_n <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end

                default: begin
                    r_state     <= IDLE;
                    r_cnt       <= '0;
                    r_buttons_n <= 1'b1;
                    r_repeating <= 1'b0;
                end
            endcase
        end
    end

    assign buttons_n   = r_buttons_n;
    assign press_pulse = r_press_pulse;
    assign repeating   = r_repeating;

endmodule : button_channel
`default_nettype wire

// File: rtl/button_conditioner.sv
`default_nettype none
// ============================================================================
// Module      : button_conditioner
// Description : Two independent button channels conditioning the raw keys
//               for the buttons PIO (active-low level, press strobe and
//               auto-repeat indication per channel).
// Revision    : 1.0 - initial release
// ============================================================================
module button_conditioner
    import button_cond_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = C_DEBOUNCE_CYCLES,
    parameter int HOLD_CYCLES     = C_HOLD_CYCLES,
    parameter int REPEAT_PERIOD   = C_REPEAT_PERIOD,
    parameter int GAP_CYCLES      = C_GAP_CYCLES
)(
    input  logic                 clk_clk,
    input  logic                 reset_reset_n,
    button_conditioner_if.slave  bus
);

    logic [1:0] w_buttons_n;
    logic [1:0] w_press_pulse;
    logic [1:0] w_repeating;

    // One identical, fully independent channel per key.
    for (genvar i = 0; i < 2; i++) begin : g_chan
        button_channel #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .HOLD_CYCLES     (HOLD_CYCLES),
            .REPEAT_PERIOD   (REPEAT_PERIOD),
            .GAP_CYCLES      (GAP_CYCLES)
        ) u_chan (
            .clk_clk       (clk_clk),
            .reset_reset_n (reset_reset_n),
            .key_n         (bus.key_n[i]),
            .buttons_n     (w_buttons_n[i]),
            .press_pulse   (w_press_pulse[i]),
            .repeating     (w_repeating[i])
        );
    end

    assign bus.buttons_n   = w_buttons_n;
    assign bus.press_pulse = w_press_pulse;
    assign bus.repeating   = w_repeating;

endmodule : button_conditioner
`default_nettype wire

// File: tb/tb_button_conditioner.sv
`default_nettype none
// ============================================================================
// Module      : tb_button_conditioner
// Description : Directed bench for button_conditioner. Stimulus pushes the
//               hand-computed output events it expects (cycle and values);
//               a negedge monitor pops and compares on every output event.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_button_conditioner;

    localparam int DEB  = 4;
    localparam int HOLD = 20;
    localparam int REP  = 10;
    localparam int GAPC = 2;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    button_conditioner_if bus();

    button_conditioner #(
        .DEBOUNCE_CYCLES (DEB),
        .HOLD_CYCLES     (HOLD),
        .REPEAT_PERIOD   (REP),
        .GAP_CYCLES      (GAPC)
    ) dut (
        .clk_clk       (clk),
        .reset_reset_n (rst_n),
        .bus           (bus.slave)
    );

    typedef struct {
        int         cyc;
        logic [1:0] b;
        logic [1:0] p;
        logic [1:0] r;
    } ev_t;

    ev_t        sb[$];
    int         cyc      = 0;
    int         n_checks = 0;
    int         n_fail   = 0;
    bit         mon_en   = 1'b0;
    logic [1:0] prev_b   = 2'b11;
    logic [1:0] prev_p   = 2'b00;
    logic [1:0] prev_r   = 2'b00;

    // Edge counter: at the negedge after rising edge N, cyc == N.
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: an output event is any press strobe or any change of level/repeating.
    always @(negedge clk) begin
        ev_t e;
        if (mon_en) begin
            if (bus.press_pulse != 2'b00 || bus.buttons_n != prev_b || bus.repeating != prev_r) begin
                n_checks++;
                if (sb.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_event cyc=%0d got b=%b p=%b r=%b, required no event",
                             cyc, bus.buttons_n, bus.press_pulse, bus.repeating);
                end else begin
                    e = sb.pop_front();
                    if (e.cyc != cyc || e.b !== bus.buttons_n || e.p !== bus.press_pulse
                        || e.r !== bus.repeating) begin
                        n_fail++;
                        $display("FAIL event got cyc=%0d b=%b p=%b r=%b, required cyc=%0d b=%b p=%b r=%b",
                                 cyc, bus.buttons_n, bus.press_pulse, bus.repeating,
                                 e.cyc, e.b, e.p, e.r);
                    end
                end
            end
            if (bus.press_pulse != 2'b00) begin
                n_checks++;
                if ((bus.press_pulse & prev_p) != 2'b00) begin
                    n_fail++;
                    $display("FAIL pulse_width cyc=%0d got p=%b after p=%b, required no back-to-back strobe",
                             cyc, bus.press_pulse, prev_p);
                end
            end
        end
        prev_b <= bus.buttons_n;
        prev_p <= bus.press_pulse;
        prev_r <= bus.repeating;
    end

    task automatic wait_n(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic expect_ev(input int dly, input logic [1:0] b, input logic [1:0] p,
                             input logic [1:0] r);
        sb.push_back('{cyc + dly, b, p, r});
    endtask

    task automatic check_out(input string name, input logic [1:0] b, input logic [1:0] p,
                             input logic [1:0] r);
        n_checks++;
        if (bus.buttons_n !== b || bus.press_pulse !== p || bus.repeating !== r) begin
            n_fail++;
            $display("FAIL %s cyc=%0d got b=%b p=%b r=%b, required b=%b p=%b r=%b",
                     name, cyc, bus.buttons_n, bus.press_pulse, bus.repeating, b, p, r);
        end
    endtask

    initial begin
        // Reset held with both keys pressed.
        rst_n     = 1'b0;
        bus.key_n = 2'b00;
        repeat (3) begin
            @(negedge clk);
            check_out("reset", 2'b11, 2'b00, 2'b00);
        end
        rst_n     = 1'b1;
        bus.key_n = 2'b11;
        mon_en    = 1'b1;
        wait_n(5);

        // Clean press on channel 0, held 12 cycles.
        bus.key_n = 2'b10;
        expect_ev(7, 2'b10, 2'b01, 2'b00);
        wait_n(12);
        bus.key_n = 2'b11;
        expect_ev(7, 2'b11, 2'b00, 2'b00);
        wait_n(12);

        // Bounce on channel 1: 3 low, 1 high, then stable low.
        bus.key_n = 2'b01;
        wait_n(3);
        bus.key_n = 2'b11;
        wait_n(1);
        bus.key_n = 2'b01;
        expect_ev(7, 2'b01, 2'b10, 2'b00);
        wait_n(12);
        bus.key_n = 2'b11;
        expect_ev(7, 2'b11, 2'b00, 2'b00);
        wait_n(12);

        // Hold channel 0 for 60 cycles: t0 = now + 7.
        bus.key_n = 2'b10;
        expect_ev(7,  2'b10, 2'b01, 2'b00);   // t0 real press
        expect_ev(27, 2'b11, 2'b00, 2'b01);   // t0+20 first gap
        expect_ev(29, 2'b10, 2'b01, 2'b01);   // t0+22
        expect_ev(37, 2'b11, 2'b00, 2'b01);
        expect_ev(39, 2'b10, 2'b01, 2'b01);   // t0+32
        expect_ev(47, 2'b11, 2'b00, 2'b01);
        expect_ev(49, 2'b10, 2'b01, 2'b01);   // t0+42
        expect_ev(57, 2'b11, 2'b00, 2'b01);
        expect_ev(59, 2'b10, 2'b01, 2'b01);   // t0+52
        expect_ev(63, 2'b10, 2'b00, 2'b00);   // release seen in REPEAT
        expect_ev(67, 2'b11, 2'b00, 2'b00);   // release debounced
        wait_n(60);
        bus.key_n = 2'b11;
        wait_n(12);

        // Release during the first gap on channel 0.
        bus.key_n = 2'b10;
        expect_ev(7,  2'b10, 2'b01, 2'b00);
        expect_ev(27, 2'b11, 2'b00, 2'b01);
        expect_ev(29, 2'b11, 2'b00, 2'b00);   // gap ends straight into IDLE
        wait_n(26);
        bus.key_n = 2'b11;
        wait_n(12);

        // Both channels together, then reset while repeating.
        bus.key_n = 2'b00;
        expect_ev(7,  2'b00, 2'b11, 2'b00);
        expect_ev(27, 2'b11, 2'b00, 2'b11);
        expect_ev(29, 2'b00, 2'b11, 2'b11);
        wait_n(31);
        rst_n     = 1'b0;
        bus.key_n = 2'b11;
        expect_ev(1, 2'b11, 2'b00, 2'b00);
        wait_n(2);
        check_out("mid_reset", 2'b11, 2'b00, 2'b00);
        rst_n = 1'b1;
        wait_n(30);

        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL drain got %0d pending events, required 0", sb.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_button_conditioner
`default_nettype wire
